// File: rtl/arb_rr_pkg.sv
// Shared definitions for the round-robin arbiter: FSM encodings, mode
// selectors and a width helper used for derived parameters.
package arb_rr_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int ARB_MODE_FREE = 0;
    localparam int ARB_MODE_HOLD = 1;

    // $clog2 with a floor of one bit, so degenerate sizes still get a real signal.
    function automatic int arb_min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_strict.sv
// Combinational strict-priority arbiter: the lowest set request bit wins.
module arb_strict
    import arb_rr_pkg::*;
#(
    parameter int WID = 4
) (
    input  logic [WID-1:0] req,
    output logic [WID-1:0] gnt
);

    // Isolate the lowest set bit (two's-complement trick).
    assign gnt = req & (~req + WID'(1));

endmodule

// File: rtl/arb_rr.sv
// Registered round-robin arbiter with optional grant hold and hold timeout.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ARB_IDLE | no owner; any request is granted on the next edge
//   ARB_BUSY | an owner holds the grant until release (hold mode only)
//
// In free mode the FSM stays in ARB_IDLE and a fresh pick is made every cycle.
module arb_rr
    import arb_rr_pkg::*;
#(
    parameter  int WID       = 4,
    parameter  int HOLD_MODE = ARB_MODE_FREE,
    parameter  int MAX_HOLD  = 0,
    localparam int IDX_W     = arb_min1_clog2(WID)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WID-1:0]   rqsts,
    input  logic             rls,
    output logic [WID-1:0]   grnts,
    output logic             grnt_vld,
    output logic [IDX_W-1:0] grnt_idx
);

    localparam int CNT_W   = arb_min1_clog2(MAX_HOLD + 1);
    localparam bit HOLD_EN = (HOLD_MODE == ARB_MODE_HOLD);

    arb_state_e       state_q, state_d;
    logic [WID-1:0]   grnts_q, grnts_d;
    logic             vld_q, vld_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    logic [WID-1:0]   mask;
    logic [WID-1:0]   cand;
    logic [WID-1:0]   m_gnt;
    logic [WID-1:0]   u_gnt;
    logic [WID-1:0]   winner;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] win_ptr;
    logic             owner_lost;
    logic             timeout;
    logic             rel_evt;
    logic             take;
    logic             clear;

    // Thermometer mask: requesters at or above the pointer get first chance.
    always_comb begin
        mask = '0;
        for (int i = 0; i < WID; i++) begin
            mask[i] = (IDX_W'(i) >= ptr_q);
        end
    end

    assign owner_lost = ~|(rqsts & grnts_q);
    assign timeout    = (MAX_HOLD != 0) && (hold_cnt_q == CNT_W'(MAX_HOLD));
    assign rel_evt    = rls | owner_lost | timeout;

    // Candidates: on a handover the current owner sits out one cycle.
    always_comb begin
        cand = rqsts;
        if (HOLD_EN && (state_q == ARB_BUSY)) begin
            cand = rqsts & ~grnts_q;
        end
    end

    arb_strict #(.WID(WID)) u_strict_masked (
        .req (cand & mask),
        .gnt (m_gnt)
    );

    arb_strict #(.WID(WID)) u_strict_full (
        .req (cand),
        .gnt (u_gnt)
    );

    assign winner = (|m_gnt) ? m_gnt : u_gnt;

    // One-hot to binary encode of the winner and the pointer that follows it.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < WID; i++) begin
            if (winner[i]) begin
                win_idx = win_idx | IDX_W'(i);
            end
        end
        win_ptr = (win_idx == IDX_W'(WID - 1)) ? '0 : win_idx + IDX_W'(1);
    end

    // Next-state, grant, pointer and hold counter.
    always_comb begin
        state_d    = state_q;
        grnts_d    = grnts_q;
        idx_d      = idx_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        take       = 1'b0;
        clear      = 1'b0;

        if (!HOLD_EN) begin
            take = 1'b1;
        end else if (state_q == ARB_IDLE) begin
            if (|rqsts) begin
                take       = 1'b1;
                state_d    = ARB_BUSY;
                hold_cnt_d = CNT_W'(1);
            end else begin
                clear = 1'b1;
            end
        end else begin
            if (rel_evt) begin
                if (|cand) begin
                    take       = 1'b1;
                    hold_cnt_d = CNT_W'(1);
                end else begin
                    clear      = 1'b1;
                    state_d    = ARB_IDLE;
                    hold_cnt_d = '0;
                end
            end else if (hold_cnt_q != '1) begin
                hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
        end

        if (take) begin
            grnts_d = winner;
            idx_d   = win_idx;
            if (|winner) begin
                ptr_d = win_ptr;
            end
        end
        if (clear) begin
            grnts_d = '0;
            idx_d   = '0;
        end
        vld_d = |grnts_d;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            grnts_q    <= '0;
            vld_q      <= 1'b0;
            idx_q      <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grnts_q    <= grnts_d;
            vld_q      <= vld_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign grnts    = grnts_q;
    assign grnt_vld = vld_q;
    assign grnt_idx = idx_q;

endmodule
